// File: rtl/code_mem.sv
// -----------------------------------------------------------------------------
// code_mem : synchronous 8051 program memory with run-time image loader.
//
// Purpose
//   Byte-wide code store with a registered fetch port (latency 1) and a
//   byte-stream loader that writes a program image while holding the CPU.
//   Addresses at or above DEPTH read back as FILL; loader bytes aimed there
//   are dropped and flagged on the sticky ld_err.
//
// Optional feature
//   CODE_MEM_MOVC_EN : adds a second, independent read port (movc_*) with the
//   same latency, FILL value and hold behaviour as the fetch port.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rom_en, rom_addr              fetch request / address
//   rom_byte, rom_valid           registered fetch data / valid
//   cpu_hold                      high while the loader owns the memory
//   ld_start, ld_base, ld_len     start a load of ld_len bytes at ld_base
//   ld_valid, ld_data, ld_ready   loader byte stream handshake
//   ld_done                       one-cycle pulse when a load completes
//   ld_err                        sticky: a load byte addressed >= DEPTH dropped
//   movc_en, movc_addr            (CODE_MEM_MOVC_EN) second read request
//   movc_byte, movc_valid         (CODE_MEM_MOVC_EN) second read data / valid
// -----------------------------------------------------------------------------
module code_mem #(
    parameter int          ADDR_W = 16,
    parameter int          DEPTH  = 1024,
    parameter logic [7:0]  FILL   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_en,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_byte,
    output logic              rom_valid,
    output logic              cpu_hold,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              ld_done,
`ifdef CODE_MEM_MOVC_EN
    output logic              ld_err,
    input  logic              movc_en,
    input  logic [ADDR_W-1:0] movc_addr,
    output logic [7:0]        movc_byte,
    output logic              movc_valid
`else
    output logic              ld_err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef CODE_MEM_MOVC_EN
    localparam int NRD = 2;
`else
    localparam int NRD = 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [7:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic              ptr_in_range;

    assign ptr_in_range = (32'(ptr_q) < DEPTH);

    // ---------------------------------------------------------------- loader
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    ptr_d   = ld_base;
                    cnt_d   = ld_len;
                    err_d   = 1'b0;
                    state_d = (ld_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // ld_ready is 1 throughout LOAD, so ld_valid alone qualifies a transfer.
                if (ld_valid) begin
                    if (ptr_in_range) begin
                        wr_en = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ADDR_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cpu_hold = (state_q != ST_IDLE);
    assign ld_ready = (state_q == ST_LOAD);
    assign ld_done  = (state_q == ST_DONE);
    assign ld_err   = err_q;

    // Memory is deliberately not cleared by rst; a byte offered on the reset
    // edge itself is not written so an aborted load leaves only prior bytes.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[ptr_q[IDX_W-1:0]] <= ld_data;
        end
    end

    // ------------------------------------------------------------ read ports
    logic              rd_en      [NRD];
    logic [ADDR_W-1:0] rd_addr    [NRD];
    logic [7:0]        rd_byte_q  [NRD];
    logic              rd_valid_q [NRD];

    assign rd_en[0]   = rom_en;
    assign rd_addr[0] = rom_addr;
    assign rom_byte   = rd_byte_q[0];
    assign rom_valid  = rd_valid_q[0];
`ifdef CODE_MEM_MOVC_EN
    assign rd_en[1]   = movc_en;
    assign rd_addr[1] = movc_addr;
    assign movc_byte  = rd_byte_q[1];
    assign movc_valid = rd_valid_q[1];
`endif

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic in_range;
            assign in_range = (32'(rd_addr[gi]) < DEPTH);

            // Requests during hold are dropped; rom_byte keeps its last value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_byte_q[gi]  <= 8'h00;
                    rd_valid_q[gi] <= 1'b0;
                end else if (rd_en[gi] && !cpu_hold) begin
                    rd_byte_q[gi]  <= in_range ? mem[rd_addr[gi][IDX_W-1:0]] : FILL;
                    rd_valid_q[gi] <= 1'b1;
                end else begin
                    rd_valid_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_code_mem.sv
// -----------------------------------------------------------------------------
// tb_code_mem : directed self-checking bench for code_mem (DEPTH=1024).
// -----------------------------------------------------------------------------
module tb_code_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_byte;
    logic        rom_valid;
    logic        cpu_hold;
    logic        ld_start;
    logic [15:0] ld_base;
    logic [15:0] ld_len;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_err;
`ifdef CODE_MEM_MOVC_EN
    logic        movc_en;
    logic [15:0] movc_addr;
    logic [7:0]  movc_byte;
    logic        movc_valid;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    code_mem #(.ADDR_W(16), .DEPTH(1024), .FILL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_byte  (rom_byte),
        .rom_valid (rom_valid),
        .cpu_hold  (cpu_hold),
        .ld_start  (ld_start),
        .ld_base   (ld_base),
        .ld_len    (ld_len),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
`ifdef CODE_MEM_MOVC_EN
        .ld_err    (ld_err),
        .movc_en   (movc_en),
        .movc_addr (movc_addr),
        .movc_byte (movc_byte),
        .movc_valid(movc_valid)
`else
        .ld_err    (ld_err)
`endif
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic fetch(input logic [15:0] a, input logic [7:0] exp, input string tag);
        rom_en   = 1'b1;
        rom_addr = a;
        tick();
        check({tag, "_byte"}, 32'(rom_byte), 32'(exp));
        check({tag, "_vld"},  32'(rom_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; rom_en = 1'b0; rom_addr = '0;
        ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
`ifdef CODE_MEM_MOVC_EN
        movc_en = 1'b0; movc_addr = '0;
`endif
        #2;
        tick(); tick();

        // ---- reset state
        check("rst_byte",  32'(rom_byte),  32'h0);
        check("rst_valid", 32'(rom_valid), 32'h0);
        check("rst_hold",  32'(cpu_hold),  32'h0);
        check("rst_ready", 32'(ld_ready),  32'h0);
        check("rst_done",  32'(ld_done),   32'h0);
        check("rst_err",   32'(ld_err),    32'h0);
        rst = 1'b0;
        tick();

        // ---- load 74 0F F5 90 at 0x0003
        ld_start = 1'b1; ld_base = 16'h0003; ld_len = 16'd4;
        tick();
        ld_start = 1'b0;
        check("l4_hold", 32'(cpu_hold), 32'h1);
        ld_valid = 1'b1;
        ld_data = 8'h74; check("l4_rdy0", 32'(ld_ready), 32'h1); tick();
        ld_data = 8'h0F; check("l4_rdy1", 32'(ld_ready), 32'h1); tick();
        ld_data = 8'hF5; check("l4_rdy2", 32'(ld_ready), 32'h1); tick();
        ld_data = 8'h90; check("l4_rdy3", 32'(ld_ready), 32'h1); tick();
        ld_valid = 1'b0;
        check("l4_done",     32'(ld_done),  32'h1);
        check("l4_done_hld", 32'(cpu_hold), 32'h1);
        check("l4_done_rdy", 32'(ld_ready), 32'h0);
        tick();
        check("l4_done_off", 32'(ld_done),  32'h0);
        check("l4_hold_off", 32'(cpu_hold), 32'h0);

        // ---- back-to-back fetch of 0x0003..0x0006
        fetch(16'h0003, 8'h74, "f3");
        fetch(16'h0004, 8'h0F, "f4");
        fetch(16'h0005, 8'hF5, "f5");
        fetch(16'h0006, 8'h90, "f6");
        rom_en = 1'b0;
        tick();
        check("idle_vld",  32'(rom_valid), 32'h0);
        check("idle_hold", 32'(rom_byte),  32'h90);

        // ---- 3-byte load at 0x0010 with gapped ld_valid; a stray ld_start is ignored
        ld_start = 1'b1; ld_base = 16'h0010; ld_len = 16'd3;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hA1; tick();
        ld_valid = 1'b0; ld_start = 1'b1; ld_base = 16'h0200; ld_len = 16'd0; tick();
        ld_start = 1'b0;
        check("gap_ready", 32'(ld_ready), 32'h1);
        check("gap_done0", 32'(ld_done),  32'h0);
        ld_valid = 1'b1; ld_data = 8'hA2; tick();
        ld_valid = 1'b0; tick();
        check("gap_done1", 32'(ld_done),  32'h0);
        ld_valid = 1'b1; ld_data = 8'hA3; tick();
        ld_valid = 1'b0;
        check("gap_done2", 32'(ld_done),  32'h1);
        tick();
        fetch(16'h0010, 8'hA1, "g10");
        fetch(16'h0011, 8'hA2, "g11");
        fetch(16'h0012, 8'hA3, "g12");
        rom_en = 1'b0;

        // ---- zero-length load: immediate done
        ld_start = 1'b1; ld_base = 16'h0050; ld_len = 16'd0;
        tick();
        ld_start = 1'b0;
        check("z_done",  32'(ld_done),  32'h1);
        check("z_ready", 32'(ld_ready), 32'h0);
        tick();
        check("z_idle",  32'(cpu_hold), 32'h0);

        // ---- 2 bytes at 0x03FF: second byte dropped, ld_err sticky
        ld_start = 1'b1; ld_base = 16'h03FF; ld_len = 16'd2;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h11; tick();
        check("e_err0", 32'(ld_err), 32'h0);
        ld_data = 8'h22; tick();
        ld_valid = 1'b0;
        check("e_done", 32'(ld_done), 32'h1);
        check("e_err1", 32'(ld_err),  32'h1);
        tick();
        check("e_sticky", 32'(ld_err), 32'h1);
        fetch(16'h03FF, 8'h11, "e3ff");
        fetch(16'h0400, 8'h00, "e400");
        fetch(16'hFFFF, 8'h00, "effff");

        // ---- fetch coincident with ld_start is served; fetch under hold is dropped
        rom_addr = 16'h0003;
        ld_start = 1'b1; ld_base = 16'h0020; ld_len = 16'd5;
        tick();
        ld_start = 1'b0;
        check("s_byte",   32'(rom_byte),  32'h74);
        check("s_vld",    32'(rom_valid), 32'h1);
        check("s_hold",   32'(cpu_hold),  32'h1);
        check("s_errclr", 32'(ld_err),    32'h0);
        ld_valid = 1'b1; ld_data = 8'h55; tick();
        check("h_vld0", 32'(rom_valid), 32'h0);
        ld_data = 8'h66; tick();
        check("h_vld1", 32'(rom_valid), 32'h0);
        ld_valid = 1'b0; rom_en = 1'b0;

        // ---- reset mid-load after 2 of 5 bytes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_hold",  32'(cpu_hold), 32'h0);
        check("r_ready", 32'(ld_ready), 32'h0);
        check("r_done0", 32'(ld_done),  32'h0);
        tick();
        check("r_done1", 32'(ld_done),  32'h0);
        fetch(16'h0020, 8'h55, "r20");
        fetch(16'h0021, 8'h66, "r21");
        rom_en = 1'b0;

`ifdef CODE_MEM_MOVC_EN
        // ---- simultaneous fetch and MOVC
        rom_en = 1'b1; rom_addr = 16'h0003;
        movc_en = 1'b1; movc_addr = 16'h0006;
        tick();
        check("m_rom",  32'(rom_byte),   32'h74);
        check("m_byte", 32'(movc_byte),  32'h90);
        check("m_vld",  32'(movc_valid), 32'h1);
        rom_en = 1'b0; movc_en = 1'b0;
        tick();
        check("m_vld0", 32'(movc_valid), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
